nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: N_NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*N_NIBBLES.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
  - Clk  input  1  sole clock; all state updates on the rising edge.
  - Reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have these operand and handshake ports:
  - Run  input  1  level start request.
  - A, B  input  W  operands, sampled only on the start edge.
  - C_in  input  1  carry-in, sampled on the start edge.
  - Sub  input  1  subtract select; present only with SUB_SUPPORT_EN.
REQ-004 The block SHALL drive the external 4-bit lookahead slice through these ports:
  - Slice_A, Slice_B  output  4  nibble operands to the slice.
  - Slice_Cin  output  1  slice carry-in.
  - Slice_S  input  4  slice sum.
  - Slice_P, Slice_G  input  1  slice group propagate and generate.
REQ-005 The block SHALL have these result ports:
  - Sum  output  W  result.
  - C_out  output  1  final carry.
  - V  output  1  signed overflow.
  - Busy  output  1  high in ADD.
  - Done  output  1  high in HOLD.

Function
REQ-006 The FSM SHALL have states IDLE, ADD and HOLD, with nibble counter cnt of width ceil(log2(N_NIBBLES)).
REQ-007 IDLE: on an edge with Run=1, the block SHALL latch A, B and C_in into A_r, B_r and c_r, clear cnt to 0, clear Sum, and go to ADD; with Run=0 it stays in IDLE.
REQ-008 ADD: Slice_A = A_r[4cnt+3:4cnt], Slice_B = B_r[4cnt+3:4cnt] and Slice_Cin = c_r, all combinational from registers.
REQ-009 On each ADD edge the block SHALL set Sum[4cnt+3:4cnt] <= Slice_S, c_r <= Slice_G | (Slice_P & c_r), and cnt <= cnt+1.
REQ-010 When cnt = N_NIBBLES-1 on an ADD edge, the block SHALL go to HOLD and set C_out <= Slice_G | (Slice_P & c_r).
REQ-011 V SHALL equal (A_r[W-1] == B_r[W-1]) & (Sum[W-1] != A_r[W-1]), registered on the same edge as C_out.
REQ-012 Latency: start edge at t0 SHALL give Done=1 in the cycle after edge t0+N_NIBBLES; default is 5 edges from start to Done.
REQ-013 HOLD: Done=1 and Sum, C_out and V stable; the block SHALL stay in HOLD while Run=1 and go to IDLE on an edge with Run=0 (one add per Run assertion).
REQ-014 Sum, C_out and V SHALL keep their values in IDLE until the next start edge.
REQ-015 Run and operand changes during ADD SHALL be ignored; A, B and C_in SHALL be sampled only on the start edge.
REQ-016 Slice_A, Slice_B and Slice_Cin SHALL be 0 outside ADD.
REQ-017 Busy SHALL be 1 only in ADD; Busy and Done SHALL never both be 1.

Reset
REQ-018 On an edge with Reset=1, the block SHALL go to IDLE and clear cnt, A_r, B_r, c_r, Sum, C_out, V, Busy and Done to 0; Reset has priority over Run.
REQ-019 Reset mid-ADD SHALL abort the operation with no partial Sum retained; the next Run=1 edge after reset release starts a fresh add.

Configuration
REQ-020 Macro SUB_SUPPORT_EN defined: the Sub port SHALL exist, and Sub=1 on the start edge SHALL latch B_r = ~B and c_r = 1, ignoring C_in.
REQ-021 With subtraction, V SHALL use the latched (inverted) B_r in REQ-011.
REQ-022 Macro SUB_SUPPORT_EN not defined: the Sub port SHALL be absent and B_r = B, c_r = C_in always.

Verification (N_NIBBLES=4)
REQ-023 A=0x1234, B=0x4321, C_in=0, Run pulse -> Done after 5 edges; Sum=0x5555, C_out=0, V=0; Busy high for exactly 4 cycles.
REQ-024 A=0xFFFF, B=0x0001, C_in=0 -> Sum=0x0000, C_out=1, V=0 (carry ripples through all 4 nibbles via c_r).
REQ-025 A=0x7FFF, B=0x0001 -> Sum=0x8000, C_out=0, V=1; then A=0x0000, B=0x0000, C_in=1 -> Sum=0x0001.
REQ-026 SUB_SUPPORT_EN, Sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, C_out=0; Sub=1, A=0x0007, B=0x0005 -> Sum=0x0002, C_out=1.
REQ-027 Reset asserted on the 2nd ADD edge -> next cycle IDLE, Sum=0, Done=0, Busy=0; a new Run with A=0x0001, B=0x0001 -> Sum=0x0002.
REQ-028 Run held high 20 cycles -> exactly one add, Done stays 1; Run low then high with new operands -> second add, Sum updates.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: walks W-bit operands through one external 4-bit lookahead slice.
// Optional build macro SUB_SUPPORT_EN adds the Sub port for A - B (two's complement).
module nibble_serial_add_ctrl #(
    parameter int N_NIBBLES = 4,
    localparam int W = 4 * N_NIBBLES,
    localparam int CNT_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Run,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
`ifdef SUB_SUPPORT_EN
    input  logic         Sub,
`endif
    output logic [3:0]   Slice_A,
    output logic [3:0]   Slice_B,
    output logic         Slice_Cin,
    input  logic [3:0]   Slice_S,
    input  logic         Slice_P,
    input  logic         Slice_G,
    output logic [W-1:0] Sum,
    output logic         C_out,
    output logic         V,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           c_r;
    logic [W-1:0]   sum_r;
    logic           c_out_r;
    logic           v_r;
    logic           busy_r;
    logic           done_r;
    logic           carry_s;
    logic           last_s;
    logic           sub_s;

`ifdef SUB_SUPPORT_EN
    assign sub_s = Sub;
`else
    assign sub_s = 1'b0;
`endif

    // Group carry out of the current nibble, fed back through c_r.
    assign carry_s = Slice_G | (Slice_P & c_r);
    assign last_s  = (cnt_r == CNT_W'(N_NIBBLES - 1));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Run) begin
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = ADD;
                end
            end
            HOLD: begin
                if (Run) begin
                    state_s = HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with status flags registered alongside the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ADD);
            done_r  <= (state_s == HOLD);
        end
    end

    // Operand capture and nibble-serial accumulation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            c_r     <= 1'b0;
            sum_r   <= {W{1'b0}};
            c_out_r <= 1'b0;
            v_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Run) begin
                        a_r   <= A;
                        b_r   <= sub_s ? ~B : B;
                        c_r   <= sub_s ? 1'b1 : C_in;
                        cnt_r <= {CNT_W{1'b0}};
                        sum_r <= {W{1'b0}};
                    end
                end
                ADD: begin
                    sum_r[{cnt_r, 2'b00} +: 4] <= Slice_S;
                    c_r   <= carry_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // Slice_S[3] is the final sum MSB being written on this edge.
                        c_out_r <= carry_s;
                        v_r     <= (a_r[W-1] == b_r[W-1]) & (Slice_S[3] != a_r[W-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice drive: current nibble during ADD, quiet otherwise.
    always_comb begin
        if (state_r == ADD) begin
            Slice_A   = a_r[{cnt_r, 2'b00} +: 4];
            Slice_B   = b_r[{cnt_r, 2'b00} +: 4];
            Slice_Cin = c_r;
        end else begin
            Slice_A   = 4'h0;
            Slice_B   = 4'h0;
            Slice_Cin = 1'b0;
        end
    end

    assign Sum   = sum_r;
    assign C_out = c_out_r;
    assign V     = v_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: vector table, scoreboard queue, reset/hold sequences.
// Define SUB_SUPPORT_EN for both files to exercise subtraction.
module tb_nibble_serial_add_ctrl;

    localparam int NN = 4;
    localparam int W  = 4 * NN;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Run;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
`ifdef SUB_SUPPORT_EN
    logic         Sub;
`endif
    logic [3:0]   Slice_A;
    logic [3:0]   Slice_B;
    logic         Slice_Cin;
    logic [3:0]   Slice_S;
    logic         Slice_P;
    logic         Slice_G;
    logic [W-1:0] Sum;
    logic         C_out;
    logic         V;
    logic         Busy;
    logic         Done;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    nibble_serial_add_ctrl #(.N_NIBBLES(NN)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .A(A), .B(B), .C_in(C_in),
`ifdef SUB_SUPPORT_EN
        .Sub(Sub),
`endif
        .Slice_A(Slice_A), .Slice_B(Slice_B), .Slice_Cin(Slice_Cin),
        .Slice_S(Slice_S), .Slice_P(Slice_P), .Slice_G(Slice_G),
        .Sum(Sum), .C_out(C_out), .V(V), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Behavioural 4-bit lookahead slice.
    logic [4:0] ab_sum;
    logic [4:0] full_sum;
    assign ab_sum   = {1'b0, Slice_A} + {1'b0, Slice_B};
    assign full_sum = ab_sum + {4'h0, Slice_Cin};
    assign Slice_S  = full_sum[3:0];
    assign Slice_G  = ab_sum[4];
    assign Slice_P  = &(Slice_A ^ Slice_B);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_add(input vec_t t, input int hold);
        exp_t e;
        int   n;
        int   busy_n;
        e.sum = t.sum; e.cout = t.cout; e.v = t.v;
        sb_q.push_back(e);
        A = t.a; B = t.b; C_in = t.cin;
`ifdef SUB_SUPPORT_EN
        Sub = t.sub;
`endif
        Run = 1'b1;
        tick();
        if (hold == 0) Run = 1'b0;
        A = W'($urandom); B = W'($urandom); C_in = 1'($urandom);
        n = 0; busy_n = 0;
        while (!Done && n < 20) begin
            if (Busy) busy_n++;
            tick();
            n++;
        end
        check("latency", n, 4);
        check("busy_cycles", busy_n, 4);
        check("busy_in_hold", {31'd0, Busy}, 0);
        check("slice_a_hold", {28'd0, Slice_A}, 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sum", {16'd0, Sum}, {16'd0, e.sum});
            check("c_out", {31'd0, C_out}, {31'd0, e.cout});
            check("v", {31'd0, V}, {31'd0, e.v});
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            check("done_held", {31'd0, Done}, 1);
            check("sum_held", {16'd0, Sum}, {16'd0, e.sum});
        end
        Run = 1'b0;
        tick();
        check("done_idle", {31'd0, Done}, 0);
        check("sum_kept", {16'd0, Sum}, {16'd0, e.sum});
        check("cout_kept", {31'd0, C_out}, {31'd0, e.cout});
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub);
        vec_t         t;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   r;
        bb = sub ? ~b : b;
        cc = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        t.a = a; t.b = b; t.cin = cin; t.sub = sub;
        t.sum  = r[W-1:0];
        t.cout = r[W];
        t.v    = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return t;
    endfunction

    function automatic vec_t fixed(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub,
                                   input logic [W-1:0] s, input logic co, input logic v);
        vec_t t;
        t.a = a; t.b = b; t.cin = cin; t.sub = sub;
        t.sum = s; t.cout = co; t.v = v;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(fixed(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0));
        vecs.push_back(fixed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(fixed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        vecs.push_back(fixed(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0));
        vecs.push_back(fixed(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(fixed(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
`ifdef SUB_SUPPORT_EN
        vecs.push_back(fixed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        vecs.push_back(fixed(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0));
        vecs.push_back(fixed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b1));
`endif
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b0));

        // Reset with Run high: reset wins.
        Reset = 1'b1; Run = 1'b1; A = 16'h1111; B = 16'h2222; C_in = 1'b1;
`ifdef SUB_SUPPORT_EN
        Sub = 1'b0;
`endif
        tick(); tick();
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_sum", {16'd0, Sum}, 0);
        check("rst_cout", {31'd0, C_out}, 0);
        check("rst_v", {31'd0, V}, 0);
        check("rst_slice", {27'd0, Slice_A, Slice_Cin}, 0);
        Run = 1'b0; Reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, Busy}, 0);

        for (int i = 0; i < vecs.size(); i++)
            do_add(vecs[i], 0);

        // Reset on the second ADD edge aborts the add.
        A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1; Run = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        check("mid_busy_pre", {31'd0, Busy}, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_sum", {16'd0, Sum}, 0);
        check("abort_busy", {31'd0, Busy}, 0);
        check("abort_done", {31'd0, Done}, 0);
        check("abort_cout", {31'd0, C_out}, 0);
        tick();
        check("abort_stay_idle", {31'd0, Busy}, 0);
        do_add(fixed(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0), 0);

        // Run held high: single add, Done held; then a second add.
        do_add(fixed(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0), 16);
        do_add(fixed(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0), 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
